// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the SRL FIFO read port and its store.
//
// Contents:
//   EMPTY_N_RST / FULL_N_RST : values the handshake flags take in reset
//   cnt_width()              : bits needed to count 0..depth entries
//
// Optional feature (see srl_fifo_read_port.sv): SRL_FIFO_OUT_REG_EN.
package srl_fifo_pkg;

  // Flag values while in reset: nothing to read, room to write.
  localparam logic EMPTY_N_RST = 1'b0;
  localparam logic FULL_N_RST  = 1'b1;

  // Width of an occupancy counter that must hold every value 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/srl_fifo_store.sv
// SRL shift-register store.
//
// On we, every entry moves one place deeper and din enters entry 0, so the
// oldest entry always sits at the highest occupied index. There is no reset:
// contents are only meaningful where the controller's occupancy says so.
//
// Ports:
//   clk  : clock, rising edge
//   we   : shift-in enable
//   addr : read address (combinational read)
//   din  : data shifted into entry 0
//   dout : mem[addr]
module srl_fifo_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Sized to the full address space so any addr value is a legal index;
  // slots at or beyond the configured depth never hold live data.
  localparam int SLOTS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = SLOTS - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_read_port.sv
// Read-side controller for an SRL FIFO; together with srl_fifo_store it is a
// complete FIFO with valid/ready handshakes on both sides.
//
// Handshake: a write is taken on a cycle where if_write & if_write_ce &
// if_full_n; a read consumes the head on a cycle where if_read & if_read_ce &
// if_empty_n. Requests outside those conditions have no effect.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   if_full_n    : 1 = a write can be accepted
//   if_write_ce  : write clock enable
//   if_write     : write request
//   if_din       : write data
//   if_empty_n   : 1 = if_dout holds valid head data
//   if_read_ce   : read clock enable
//   if_read      : read request / consume head
//   if_dout      : head-of-queue data
//
// Optional feature, macro SRL_FIFO_OUT_REG_EN: adds a registered output stage
// after the store (2-cycle write-to-valid latency, capacity DEPTH+1, if_full_n
// still describes only the store). Undefined: if_dout is read combinationally
// from the store.
module srl_fifo_read_port
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam int                CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [CNT_W-1:0]      cnt_next_m1;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  store_vld;   // store holds at least one entry
  logic                  full_n;
  logic                  wr;
  logic                  rd;
  logic                  pop;         // head leaves the store this cycle
  logic [DATA_WIDTH-1:0] store_dout;

  assign wr = if_write & if_write_ce & full_n;

`ifdef SRL_FIFO_OUT_REG_EN
  logic                  dout_vld;
  logic [DATA_WIDTH-1:0] dout_reg;

  assign rd  = if_read & if_read_ce & dout_vld;
  // Refill the output stage whenever it is empty or being consumed.
  assign pop = store_vld & (~dout_vld | rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_vld <= 1'b0;
      dout_reg <= '0;
    end else if (~dout_vld | rd) begin
      dout_vld <= store_vld;
      if (store_vld) begin
        dout_reg <= store_dout;
      end
    end
  end

  assign if_empty_n = dout_vld;
  assign if_dout    = dout_reg;
`else
  assign rd  = if_read & if_read_ce & store_vld;
  assign pop = rd;

  assign if_empty_n = store_vld;
  assign if_dout    = store_dout;
`endif

  assign if_full_n = full_n;

  always_comb begin
    cnt_next = cnt;
    if (wr & ~pop) begin
      cnt_next = cnt + 1'b1;
    end else if (pop & ~wr) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Head lives at cnt-1. On a simultaneous shift and pop cnt is unchanged, so
  // the address stays put and the shift slides the next-oldest entry into it.
  assign cnt_next_m1 = cnt_next - 1'b1;
  assign addr_next   = (cnt_next != '0) ? cnt_next_m1[ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      addr      <= '0;
      store_vld <= EMPTY_N_RST;
      full_n    <= FULL_N_RST;
    end else begin
      cnt       <= cnt_next;
      addr      <= addr_next;
      store_vld <= (cnt_next != '0);
      full_n    <= (cnt_next != DEPTH_C);
    end
  end

  srl_fifo_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clk  (clk),
    .we   (wr),
    .addr (addr),
    .din  (if_din),
    .dout (store_dout)
  );

endmodule

// File: tb/tb_srl_fifo_read_port.sv
// Bench for srl_fifo_read_port (default build, output register disabled).
// The reference is a plain queue of capacity DEPTH: writes are pushed when
// the queue has room, reads pop the front when it is non-empty, reset empties
// it. Flags and head data are compared against that queue every cycle.
module tb_srl_fifo_read_port;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_full_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;

  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          popped = 1'b0;   // monitor consumed the front this cycle
  logic          run_done = 1'b0;

  srl_fifo_read_port #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_full_n   (if_full_n),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_empty_n  (if_empty_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic w, input logic wce,
                      input logic [DW-1:0] d, input logic r, input logic rce);
    reset       = rst;
    if_write    = w;
    if_write_ce = wce;
    if_din      = d;
    if_read     = r;
    if_read_ce  = rce;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_only(input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic rd_only();
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus side of the scoreboard ----------------
  // At each edge, record what the queue gains. Room is judged on the
  // occupancy before this cycle's read, so a full FIFO drops a write even
  // when a read is taken in the same cycle.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (if_write && if_write_ce &&
                 (exp_q.size() + (popped ? 1 : 0)) != DEPTH) begin
      exp_q.push_back(if_din);
    end
    popped <= 1'b0;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if ($time > 10 && !run_done) begin
      checks++;
      if (if_empty_n !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL empty_n t=%0t got %b exp %b", $time, if_empty_n, exp_q.size() != 0);
      end
      checks++;
      if (if_full_n !== (exp_q.size() != DEPTH)) begin
        errors++;
        $display("FAIL full_n t=%0t got %b exp %b", $time, if_full_n, exp_q.size() != DEPTH);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (if_dout !== exp_q[0]) begin
          errors++;
          $display("FAIL head t=%0t got %02h exp %02h", $time, if_dout, exp_q[0]);
        end
        if (if_read && if_read_ce) begin
          void'(exp_q.pop_front());
          popped = 1'b1;
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    // Writes held during reset must not land.
    step(1'b1, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hE2, 1'b0, 1'b1);
    idle();

    // Fill, overfill, drain, read past empty.
    wr_only(8'h11); wr_only(8'h22); wr_only(8'h33); wr_only(8'h44);
    wr_only(8'h55);
    rd_only(); rd_only(); rd_only(); rd_only();
    rd_only();
    idle();

    // Simultaneous read and write at cnt=2.
    wr_only(8'h11); wr_only(8'h22);
    step(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
    rd_only(); rd_only();
    idle();

    // Full with read and write together: write dropped, then cnt=3.
    wr_only(8'hA1); wr_only(8'hA2); wr_only(8'hA3); wr_only(8'hA4);
    step(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    idle();
    rd_only(); rd_only(); rd_only();
    idle();

    // ce low on either side is ignored.
    step(1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
    wr_only(8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    rd_only();
    idle();

    // Reset at cnt=3 together with a write, then recover.
    wr_only(8'hB1); wr_only(8'hB2); wr_only(8'hB3);
    step(1'b1, 1'b1, 1'b1, 8'hB4, 1'b1, 1'b1);
    wr_only(8'hAA);
    rd_only();
    idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 7) != 0), 8'($urandom),
           $urandom_range(0, 1), ($urandom_range(0, 7) != 0));
    end
    idle();
    idle();

    run_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
